// File: rtl/aes_bridge_pkg.sv
// Shared types and constants for the CPU <-> AES block bridge.
// No logic; the constants fix word/block geometry and mode encoding.
// The state enum is shared by the bridge FSM and any future debug taps.
package aes_bridge_pkg;

  localparam int WORD_W    = 16;
  localparam int BLOCK_W   = 128;
  localparam int NUM_WORDS = BLOCK_W / WORD_W;
  localparam int IDX_W     = $clog2(NUM_WORDS);

  // Index of the least significant (last transferred) word
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  localparam logic AES_ENC = 1'b0;
  localparam logic AES_DEC = 1'b1;

  typedef enum logic [2:0] {
    GATHER = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    DRAIN  = 3'd3,
    FLUSH  = 3'd4
  } state_t;

endpackage

// File: rtl/aes_word_buf.sv
// 128-bit block register addressable as eight 16-bit words, word 0 = MSW.
// Writes/loads land on the next clock edge; the read mux is combinational.
// No flow control of its own; the owner decides when to write or load.
module aes_word_buf
  import aes_bridge_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [WORD_W-1:0]  wr_word,
  input  logic               ld_en,
  input  logic [BLOCK_W-1:0] ld_block,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [WORD_W-1:0]  rd_word,
  output logic [BLOCK_W-1:0] block
);

  // words[NUM_WORDS-1] holds bits [127:112], i.e. word index 0
  logic [NUM_WORDS-1:0][WORD_W-1:0] words;

  // Full-block load wins over a single word write
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      words <= '0;
    end else if (ld_en) begin
      words <= ld_block;
    end else if (wr_en) begin
      words[LAST_IDX - wr_idx] <= wr_word;
    end
  end

  assign rd_word = words[LAST_IDX - rd_idx];
  assign block   = words;

endmodule

// File: rtl/aes_word_bridge.sv
// Packs eight CPU words into an AES block, issues it, and returns the result word by word.
// Block valid one cycle after the 8th write; first result word one cycle after result capture.
// Valid/ready on every side; a stalled consumer holds the current block/word indefinitely.
module aes_word_bridge
  import aes_bridge_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_n,
  input  logic               abort_i,
  input  logic               wr_v_i,
  input  logic [WORD_W-1:0]  wr_data_i,
  input  logic               wr_mode_i,
  output logic               wr_ready_o,
  output logic               blk_v_o,
  output logic [BLOCK_W-1:0] blk_data_o,
  output logic               blk_mode_o,
  input  logic               blk_ready_i,
  input  logic               res_v_i,
  input  logic [BLOCK_W-1:0] res_data_i,
  output logic               res_ready_o,
  output logic               rd_v_o,
  output logic [WORD_W-1:0]  rd_data_o,
  output logic               rd_last_o,
  input  logic               rd_ready_i,
  output logic               busy_o,
  output logic [IDX_W-1:0]   word_cnt_o
);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   cnt, cnt_nxt;
  logic               mode;
  logic               wr_fire, blk_fire, res_fire, rd_fire;
  logic               gather_wr, result_ld;
  logic [BLOCK_W-1:0] gather_block, result_block;
  logic [WORD_W-1:0]  gather_word, result_word;
  logic               unused;

  // Handshakes use the registered-state readies, matching what the outputs show
  assign wr_fire  = (state == GATHER) && wr_v_i;
  assign blk_fire = (state == ISSUE)  && blk_ready_i;
  assign res_fire = ((state == WAIT) || (state == FLUSH)) && res_v_i;
  assign rd_fire  = (state == DRAIN)  && rd_ready_i;

  // An aborted write is dropped; a result is only kept when it completes a live transaction
  assign gather_wr = wr_fire && !abort_i;
  assign result_ld = (state == WAIT) && res_v_i && !abort_i;

  aes_word_buf u_gather_buf (
    .clk      (clk_i),
    .reset_n  (reset_n),
    .wr_en    (gather_wr),
    .wr_idx   (cnt),
    .wr_word  (wr_data_i),
    .ld_en    (1'b0),
    .ld_block ('0),
    .rd_idx   (cnt),
    .rd_word  (gather_word),
    .block    (gather_block)
  );

  aes_word_buf u_result_buf (
    .clk      (clk_i),
    .reset_n  (reset_n),
    .wr_en    (1'b0),
    .wr_idx   ('0),
    .wr_word  ('0),
    .ld_en    (result_ld),
    .ld_block (res_data_i),
    .rd_idx   (cnt),
    .rd_word  (result_word),
    .block    (result_block)
  );

  assign unused = ^{gather_word, result_block};

  // State, counter and latched mode registers; reset overrides everything
  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state <= GATHER;
      cnt   <= '0;
      mode  <= AES_ENC;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (gather_wr && (cnt == '0)) begin
        mode <= wr_mode_i;
      end
    end
  end

  // Next-state and counter update
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      GATHER: begin
        if (abort_i) begin
          cnt_nxt = '0;
        end else if (wr_fire) begin
          cnt_nxt = cnt + IDX_W'(1);
          if (cnt == LAST_IDX) begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (abort_i) begin
          state_nxt = GATHER;
          cnt_nxt   = '0;
        end else if (blk_fire) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // The core owns the block now, so an abort must still swallow its result
        if (res_fire) begin
          state_nxt = abort_i ? GATHER : DRAIN;
        end else if (abort_i) begin
          state_nxt = FLUSH;
        end
        cnt_nxt = '0;
      end
      DRAIN: begin
        if (abort_i) begin
          state_nxt = GATHER;
          cnt_nxt   = '0;
        end else if (rd_fire) begin
          cnt_nxt = cnt + IDX_W'(1);
          if (cnt == LAST_IDX) begin
            state_nxt = GATHER;
          end
        end
      end
      FLUSH: begin
        if (res_fire) begin
          state_nxt = GATHER;
        end
        cnt_nxt = '0;
      end
      default: begin
        state_nxt = GATHER;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decoded from registered state; everything forced low while reset is held
  always_comb begin
    wr_ready_o  = 1'b0;
    blk_v_o     = 1'b0;
    blk_data_o  = '0;
    blk_mode_o  = 1'b0;
    res_ready_o = 1'b0;
    rd_v_o      = 1'b0;
    rd_data_o   = '0;
    rd_last_o   = 1'b0;
    busy_o      = 1'b0;
    word_cnt_o  = '0;
    if (reset_n) begin
      blk_data_o = gather_block;
      blk_mode_o = mode;
      rd_data_o  = result_word;
      word_cnt_o = cnt;
      busy_o     = (state != GATHER);
      case (state)
        GATHER: wr_ready_o = 1'b1;
        ISSUE:  blk_v_o = 1'b1;
        WAIT:   res_ready_o = 1'b1;
        DRAIN: begin
          rd_v_o    = 1'b1;
          rd_last_o = (cnt == LAST_IDX);
        end
        FLUSH:  res_ready_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
